ysyx_22040237_ifu: RTL and testbench
====================================

Name: ysyx_22040237_ifu

Overview:
Instruction fetch unit for the ysyx_22040237 RV64 core. It is the producer side of the decode interface: it owns the PC and fetches 32-bit instructions over a req/gnt/rvalid instruction-memory port. It presents each instruction and its PC to the IDU through a valid/ready handshake. It accepts branch/jump redirects from the EXU and a halt request on ebreak.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, PC fetched first after reset
INST_W, 32, instruction width
ADDR_W, 64, PC and fetch address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch address, bits [1:0] always 00
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid, earliest 1 cycle after gnt
imem_rdata_i  in  INST_W  fetched instruction
imem_err_i  in  1  access fault, qualified by rvalid
redirect_valid_i  in  1  taken branch/jump this cycle
redirect_pc_i  in  ADDR_W  redirect target
halt_i  in  1  stop fetching (ebreak retired)
inst_valid_o  out  1  instruction valid toward IDU
inst_ready_i  in  1  IDU accepts instruction
inst_o  out  INST_W  instruction to IDU inst_i
pc_o  out  ADDR_W  PC of inst_o, to IDU pc_i
fetch_err_o  out  1  inst_o carries an access fault

Behaviour:
- Reset is asynchronous on rst_n low.
  - Registers: state=IDLE, fetch_pc=PC_RESET, drop=0, halted=0.
  - Outputs: all outputs are 0.
- States: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: one cycle after reset release -> REQ.
- REQ:
  - imem_req_o=1, imem_addr_o={fetch_pc[63:2],2'b00}.
  - gnt=1 -> WAIT.
  - Address holds stable until gnt, except on redirect.
- WAIT:
  - imem_req_o=0. Wait for rvalid.
  - rvalid with drop=1 -> discard the response, clear drop, go to REQ.
  - rvalid with drop=0 -> register inst_o=rdata, pc_o=fetch_pc, fetch_err_o=err. On err, inst_o=0. Go to HOLD.
- HOLD:
  - inst_valid_o=1; inst_o/pc_o/fetch_err_o are stable while ready=0.
  - ready=1 -> fetch_pc+=4 (64-bit wrap), inst_valid_o=0 next cycle, go to REQ.
  - Rate is one instruction per 3 cycles minimum; no overlap is required.
- Redirect has the highest priority and is ignored in IDLE and HALT.
  - fetch_pc <= {redirect_pc_i[63:2],2'b00} next cycle.
  - inst_valid_o is 0 next cycle.
  - In HOLD: drops the held instruction and goes to REQ. Redirect+ready in the same cycle still goes to the redirect target, never pc+4.
  - In REQ without gnt: stays in REQ; the address changes to the target next cycle.
  - In REQ with gnt same cycle: drop=1 -> WAIT.
  - In WAIT without rvalid: drop=1, stay in WAIT.
  - In WAIT with rvalid same cycle: the response is discarded -> REQ.
- Halt:
  - halt_i is sampled into sticky halted.
  - HALT is entered from REQ before gnt, and from HOLD after the handshake or a redirect.
  - An outstanding transaction always completes first. Its response is delivered normally unless dropped.
  - HALT: no requests, inst_valid_o=0, exit only by reset.
- rvalid in IDLE/REQ/HOLD/HALT is ignored. This covers stale responses after a reset mid-WAIT.
- At most one outstanding request at any time.

Test Plan:
1. Reset release, gnt same cycle as req, rvalid next cycle with rdata=0x00100093 -> req/addr=0x80000000 in cycle 2; inst_valid_o=1, inst_o=0x00100093, pc_o=0x80000000; ready=1 -> next addr 0x80000004.
2. HOLD with ready=0 for 5 cycles -> inst_o/pc_o constant, imem_req_o=0 throughout; ready=1 -> exactly one handshake, pc advances by 4.
3. Redirect to 0x80000100 in WAIT, then stale rvalid rdata=0xDEADBEEF -> not delivered; next addr 0x80000100; delivered pc_o=0x80000100.
4. Redirect to 0x80000200 with ready=1 in HOLD -> next addr 0x80000200, not pc+4; redirect to 0x80000203 -> addr 0x80000200.
5. rvalid with imem_err_i=1 -> inst_valid_o=1, fetch_err_o=1, inst_o=0.
6. halt_i in REQ before gnt -> HALT, no further req; rst_n low mid-WAIT -> outputs 0 immediately, later rvalid ignored, refetch at 0x80000000.

Source files
------------

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over a
// req/gnt/rvalid port and hands it to the IDU through a valid/ready handshake.
module ysyx_22040237_ifu #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              imem_err_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_err_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_d;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              drop, drop_d;
  logic              halted;
  logic              capture;
  logic              req;

  assign redirect_tgt = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, PC/drop updates and request generation
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    drop_d     = drop;
    capture    = 1'b0;
    req        = 1'b0;
    unique case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_valid_i) fetch_pc_d = redirect_tgt;
        if (halted) begin
          // Halt only before a request is granted; nothing is outstanding here.
          state_d = HALT;
        end else begin
          req = 1'b1;
          if (imem_gnt_i) begin
            state_d = WAIT;
            drop_d  = redirect_valid_i;
          end
        end
      end
      WAIT: begin
        if (redirect_valid_i) fetch_pc_d = redirect_tgt;
        if (imem_rvalid_i) begin
          drop_d = 1'b0;
          if (drop || redirect_valid_i) begin
            state_d = REQ;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_valid_i) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid_i) begin
          fetch_pc_d = redirect_tgt;
          state_d    = halted ? HALT : REQ;
        end else if (inst_ready_i) begin
          fetch_pc_d = fetch_pc + ADDR_W'(4);
          state_d    = halted ? HALT : REQ;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC, drop flag and sticky halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= PC_RESET;
      drop     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_d;
      drop     <= drop_d;
      halted   <= halted | halt_i;
    end
  end

  // Delivered instruction register, held stable through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_o      <= '0;
      pc_o        <= '0;
      fetch_err_o <= 1'b0;
    end else if (capture) begin
      inst_o      <= imem_err_i ? '0 : imem_rdata_i;
      pc_o        <= fetch_pc;
      fetch_err_o <= imem_err_i;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = req ? {fetch_pc[ADDR_W-1:2], 2'b00} : '0;
  assign inst_valid_o = (state == HOLD);

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Testbench for ysyx_22040237_ifu: directed scenarios followed by a randomized
// run against a transaction-level model of the expected PC stream and memory.
module tb_ysyx_22040237_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        halt_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        fetch_err_o;

  int errors = 0;
  int checks = 0;

  ysyx_22040237_ifu #(.ADDR_W(64), .INST_W(32), .PC_RESET(64'h0000_0000_8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .pc_o(pc_o), .fetch_err_o(fetch_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents and fault map as a pure function of the word address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
  endfunction

  function automatic logic err_at(input logic [63:0] a);
    return a[9:2] == 8'h55;
  endfunction

  initial begin : stim
    int          outstanding;
    int          lat;
    int          idle;
    int          hs;
    logic        issued;
    logic [63:0] resp_addr;
    logic [63:0] exp_pc;

    rst_n = 1'b1;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0; imem_err_i = 0;
    redirect_valid_i = 0; redirect_pc_i = '0; halt_i = 0; inst_ready_i = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_err", fetch_err_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_req", imem_req_o, 0);

    // First fetch with immediate grant and one-cycle response
    tick();
    chk("t1_req", imem_req_o, 1);
    chk("t1_addr", imem_addr_o, 64'h8000_0000);
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    chk("t1_wait_req", imem_req_o, 0);
    imem_rvalid_i = 1; imem_rdata_i = 32'h0010_0093; tick(); imem_rvalid_i = 0;
    chk("t1_valid", inst_valid_o, 1);
    chk("t1_inst", inst_o, 32'h0010_0093);
    chk("t1_pc", pc_o, 64'h8000_0000);

    // Back-pressure: output held stable while ready is low
    for (int i = 0; i < 5; i++) begin
      imem_rdata_i = $urandom; imem_rvalid_i = 1'($urandom_range(0, 1));
      tick();
      chk("t2_hold_valid", inst_valid_o, 1);
      chk("t2_hold_inst", inst_o, 32'h0010_0093);
      chk("t2_hold_pc", pc_o, 64'h8000_0000);
      chk("t2_hold_req", imem_req_o, 0);
    end
    imem_rvalid_i = 0;
    inst_ready_i = 1; tick(); inst_ready_i = 0;
    chk("t2_valid_drop", inst_valid_o, 0);
    chk("t2_next_addr", imem_addr_o, 64'h8000_0004);

    // Redirect while waiting: stale response must be discarded
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    redirect_valid_i = 1; redirect_pc_i = 64'h8000_0100; tick(); redirect_valid_i = 0;
    chk("t3_wait_req", imem_req_o, 0);
    chk("t3_wait_valid", inst_valid_o, 0);
    imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF; tick(); imem_rvalid_i = 0;
    chk("t3_stale_valid", inst_valid_o, 0);
    chk("t3_redir_addr", imem_addr_o, 64'h8000_0100);
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    imem_rvalid_i = 1; imem_rdata_i = 32'h1234_5678; tick(); imem_rvalid_i = 0;
    chk("t3_valid", inst_valid_o, 1);
    chk("t3_pc", pc_o, 64'h8000_0100);
    chk("t3_inst", inst_o, 32'h1234_5678);

    // Redirect together with ready wins over pc+4; target is word-aligned
    redirect_valid_i = 1; redirect_pc_i = 64'h8000_0200; inst_ready_i = 1; tick();
    inst_ready_i = 0;
    chk("t4_valid", inst_valid_o, 0);
    chk("t4_addr", imem_addr_o, 64'h8000_0200);
    redirect_pc_i = 64'h8000_0203; tick(); redirect_valid_i = 0;
    chk("t4_req", imem_req_o, 1);
    chk("t4_aligned_addr", imem_addr_o, 64'h8000_0200);

    // Access fault
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    imem_rvalid_i = 1; imem_err_i = 1; imem_rdata_i = 32'hFFFF_FFFF; tick();
    imem_rvalid_i = 0; imem_err_i = 0;
    chk("t5_valid", inst_valid_o, 1);
    chk("t5_err", fetch_err_o, 1);
    chk("t5_inst", inst_o, 0);
    chk("t5_pc", pc_o, 64'h8000_0200);
    inst_ready_i = 1; tick(); inst_ready_i = 0;
    chk("t5_next_addr", imem_addr_o, 64'h8000_0204);

    // PC increment wraps at 64 bits
    redirect_valid_i = 1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC; tick(); redirect_valid_i = 0;
    chk("wrap_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    imem_rvalid_i = 1; imem_rdata_i = 32'h0000_0013; tick(); imem_rvalid_i = 0;
    chk("wrap_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready_i = 1; tick(); inst_ready_i = 0;
    chk("wrap_next_addr", imem_addr_o, 64'h0);
    chk("wrap_req", imem_req_o, 1);

    // Halt before grant: no further requests, even with redirects offered
    halt_i = 1; tick(); halt_i = 0;
    for (int i = 0; i < 6; i++) begin
      imem_gnt_i = 1'($urandom_range(0, 1));
      redirect_valid_i = (i == 2); redirect_pc_i = 64'h8000_0400;
      tick();
      chk("t6_halt_req", imem_req_o, 0);
      chk("t6_halt_valid", inst_valid_o, 0);
    end
    imem_gnt_i = 0; redirect_valid_i = 0;

    // Reset in the middle of a transaction, then a stale response
    rst_n = 0; #2 rst_n = 1; tick();
    chk("t6_refetch_addr", imem_addr_o, 64'h8000_0000);
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    imem_rdata_i = 32'hCAFE_F00D; inst_ready_i = 1;
    rst_n = 0; #1;
    chk("t6_midrst_req", imem_req_o, 0);
    chk("t6_midrst_valid", inst_valid_o, 0);
    chk("t6_midrst_inst", inst_o, 0);
    chk("t6_midrst_pc", pc_o, 0);
    tick(); rst_n = 1;
    imem_rvalid_i = 1; tick(); imem_rvalid_i = 0;
    chk("t6_stale_valid", inst_valid_o, 0);
    chk("t6_post_req", imem_req_o, 1);
    chk("t6_post_addr", imem_addr_o, 64'h8000_0000);

    // Randomized run: the model tracks only which PC the fetcher should be on
    outstanding = 0; lat = 0; idle = 0; hs = 0;
    resp_addr = '0; exp_pc = 64'h8000_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (imem_req_o) begin
        chk("rnd_single_outstanding", 64'(outstanding), 0);
        chk("rnd_addr", imem_addr_o, exp_pc);
      end
      if (inst_valid_o) begin
        chk("rnd_pc", pc_o, exp_pc);
        chk("rnd_err", fetch_err_o, err_at(exp_pc));
        chk("rnd_inst", inst_o, err_at(exp_pc) ? 32'h0 : mem_word(exp_pc));
      end
      if (imem_req_o || inst_valid_o) idle = 0;
      else idle++;
      if (idle > 20) begin
        chk("rnd_liveness", 64'(idle), 0);
        break;
      end

      issued = (outstanding != 0) && (lat == 0);
      if (issued) begin
        imem_rvalid_i = 1; imem_rdata_i = mem_word(resp_addr); imem_err_i = err_at(resp_addr);
      end else if (outstanding == 0 && $urandom_range(0, 9) == 0) begin
        imem_rvalid_i = 1; imem_rdata_i = $urandom; imem_err_i = 1'($urandom_range(0, 1));
      end else begin
        imem_rvalid_i = 0; imem_rdata_i = $urandom; imem_err_i = 0;
      end
      imem_gnt_i       = imem_req_o && ($urandom_range(0, 1) == 1);
      inst_ready_i     = 1'($urandom_range(0, 1));
      redirect_valid_i = ($urandom_range(0, 12) == 0);
      redirect_pc_i    = {32'h0, 16'h8000, 16'($urandom)};

      if (redirect_valid_i) exp_pc = {redirect_pc_i[63:2], 2'b00};
      else if (inst_valid_o && inst_ready_i) begin
        exp_pc = exp_pc + 64'd4;
        hs++;
      end
      if (issued) outstanding = 0;
      else if (outstanding != 0) lat--;
      if (imem_req_o && imem_gnt_i) begin
        outstanding = 1;
        resp_addr   = imem_addr_o;
        lat         = $urandom_range(0, 2);
      end
      tick();
    end
    chk("rnd_progress", 64'(hs > 50), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
